// File: rtl/uart_tx_if.sv
// ============================================================================
//  Module      : uart_tx_if
//  Description : Handshake/data bundle between a UART transmitter and its
//                client. The slave modport is the transmitter's view and the
//                master modport is the client's view.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface uart_tx_if;
   logic       i_tx_start;     // request to send i_din
   logic       i_s_tick;       // 16x oversampling enable, one clk wide
   logic [7:0] i_din;          // data byte, low DBIT bits are sent
   logic       o_tx_done_tick; // one-clk pulse at the end of the stop interval
   logic       o_tx_busy;      // high whenever the transmitter is not idle
   logic       o_tx;           // registered serial line, idle-high

   modport master (
      output i_tx_start, i_s_tick, i_din,
      input  o_tx_done_tick, o_tx_busy, o_tx
   );

   modport slave (
      input  i_tx_start, i_s_tick, i_din,
      output o_tx_done_tick, o_tx_busy, o_tx
   );
endinterface

`default_nettype wire

// File: rtl/uart_tx.sv
// ============================================================================
//  Module      : uart_tx
//  Description : UART serialiser. Sends a start bit, DBIT data bits LSB first,
//                an optional even-parity bit and a stop interval of SB_TICK
//                oversampling ticks. Every bit except stop lasts 16 s_ticks.
//                Optional feature macro: UART_TX_PARITY_EN (adds parity bit).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_tx #(
   parameter int DBIT    = 8,   // data bits per frame, 5..8
   parameter int SB_TICK = 16   // stop interval in s_ticks, 16..32
) (
   input  wire logic clk,
   input  wire logic reset,
   uart_tx_if.slave  bus
);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_START  = 3'd1;
   localparam logic [2:0] c_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
   localparam logic [2:0] c_PARITY = 3'd3;
`endif
   localparam logic [2:0] c_STOP   = 3'd4;

   // Tick count at which a 16-tick bit ends, and at which the stop ends.
   localparam logic [4:0] c_BIT_TICK_LAST  = 5'd15;
   localparam logic [4:0] c_STOP_TICK_LAST = 5'(SB_TICK - 1);
   localparam logic [2:0] c_LAST_DATA_BIT  = 3'(DBIT - 1);

   logic [2:0] r_state;
   logic [4:0] r_tick_cnt;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_shift;
   logic       r_tx;
`ifdef UART_TX_PARITY_EN
   logic       r_parity;
`endif

   logic w_bit_end;
   logic w_stop_end;

   assign w_bit_end  = bus.i_s_tick && (r_tick_cnt == c_BIT_TICK_LAST);
   assign w_stop_end = bus.i_s_tick && (r_tick_cnt == c_STOP_TICK_LAST);

   // Frame sequencer: all state, counters and the serial line advance only on
   // s_tick, except acceptance, which drives the start bit one clk later.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= c_IDLE;
         r_tick_cnt <= 5'd0;
         r_bit_cnt  <= 3'd0;
         r_shift    <= 8'd0;
         r_tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         case (r_state)
            c_IDLE: begin
               if (bus.i_tx_start) begin
                  r_state    <= c_START;
                  r_shift    <= bus.i_din;
                  r_tick_cnt <= 5'd0;
                  r_bit_cnt  <= 3'd0;
                  r_tx       <= 1'b0;
`ifdef UART_TX_PARITY_EN
                  // Even parity: the parity bit makes the total count of ones even.
                  r_parity   <= ^bus.i_din[DBIT-1:0];
`endif
               end
            end
            c_START: begin
               if (w_bit_end) begin
                  r_tick_cnt <= 5'd0;
                  r_state    <= c_DATA;
                  r_tx       <= r_shift[0];
               end else if (bus.i_s_tick) begin
                  r_tick_cnt <= r_tick_cnt + 5'd1;
               end
            end
            c_DATA: begin
               if (w_bit_end) begin
                  r_tick_cnt <= 5'd0;
                  r_shift    <= r_shift >> 1;
                  if (r_bit_cnt == c_LAST_DATA_BIT) begin
`ifdef UART_TX_PARITY_EN
                     r_state <= c_PARITY;
                     r_tx    <= r_parity;
`else
                     r_state <= c_STOP;
                     r_tx    <= 1'b1;
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     // Next bit is the one that lands in bit 0 after this shift.
                     r_tx      <= r_shift[1];
                  end
               end else if (bus.i_s_tick) begin
                  r_tick_cnt <= r_tick_cnt + 5'd1;
               end
            end
`ifdef UART_TX_PARITY_EN
            c_PARITY: begin
               if (w_bit_end) begin
                  r_tick_cnt <= 5'd0;
                  r_state    <= c_STOP;
                  r_tx       <= 1'b1;
               end else if (bus.i_s_tick) begin
                  r_tick_cnt <= r_tick_cnt + 5'd1;
               end
            end
`endif
            c_STOP: begin
               if (w_stop_end) begin
                  r_tick_cnt <= 5'd0;
                  r_state    <= c_IDLE;
               end else if (bus.i_s_tick) begin
                  r_tick_cnt <= r_tick_cnt + 5'd1;
               end
            end
            default: begin
               r_state <= c_IDLE;
               r_tx    <= 1'b1;
            end
         endcase
      end
   end

   // Done is flagged in the clk that closes the stop interval, while the
   // state is still stop, so a start request in that clk is not accepted.
   assign bus.o_tx_done_tick = (r_state == c_STOP) && w_stop_end;
   assign bus.o_tx_busy      = (r_state != c_IDLE);
   assign bus.o_tx           = r_tx;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Scoreboard bench for uart_tx. Stimulus pushes the expected
//                frame; a monitor per DUT rebuilds each frame from the serial
//                line and compares it bit window by bit window.
//                dut0 uses the defaults, dut1 uses SB_TICK=32.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

   localparam int DBIT = 8;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   typedef struct {
      logic [7:0] din;
      bit         par;    // hand-computed even parity of din
      int         div;    // clks per s_tick
      int         sb;     // stop ticks of the target DUT
      bit         abort;  // frame is cut short by reset
      int         gap;    // required clks from previous done to tx low, 0 = unchecked
   } frame_t;

   logic clk;
   logic reset;
   uart_tx_if bus0 ();
   uart_tx_if bus1 ();

   uart_tx dut0 (.clk(clk), .reset(reset), .bus(bus0));
   uart_tx #(.DBIT(8), .SB_TICK(32)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

   logic [1:0] m_tx, m_busy, m_done;
   assign m_tx   = {bus1.o_tx, bus0.o_tx};
   assign m_busy = {bus1.o_tx_busy, bus0.o_tx_busy};
   assign m_done = {bus1.o_tx_done_tick, bus0.o_tx_done_tick};

   frame_t sbq0[$];
   frame_t sbq1[$];
   int     n_total = 0;
   int     n_bad   = 0;
   int     cyc     = 0;
   int     div     = 1;
   int     tcnt    = 0;
   int     dn_cnt[2];
   int     exp_dn[2];
   bit     mon_active[2];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Counts every done pulse, wanted or not.
   initial begin
      dn_cnt[0] = 0;
      dn_cnt[1] = 0;
      forever begin
         @(negedge clk);
         if (m_done[0]) dn_cnt[0]++;
         if (m_done[1]) dn_cnt[1]++;
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance one clk; s_tick fires when the phase counter wraps.
   task automatic step();
      @(posedge clk);
      #1;
      tcnt = (tcnt >= div - 1) ? 0 : tcnt + 1;
      bus0.i_s_tick = (tcnt == div - 1);
      bus1.i_s_tick = (tcnt == div - 1);
   endtask

   task automatic push(input int d, input logic [7:0] v, input bit par, input int dv,
                       input bit abort, input int gap);
      frame_t f;
      f.din = v; f.par = par; f.div = dv; f.abort = abort; f.gap = gap;
      f.sb  = (d == 0) ? 16 : 32;
      if (d == 0) sbq0.push_back(f); else sbq1.push_back(f);
      if (!abort) exp_dn[d]++;
   endtask

   // One-clk start pulse. The tick phase is set so the first s_tick after
   // acceptance lands div clks later, making the start bit exactly 16*div clks.
   task automatic send(input int d, input logic [7:0] v, input bit par, input int dv,
                       input bit abort);
      push(d, v, par, dv, abort, 0);
      div  = dv;
      tcnt = dv - 1;
      bus0.i_s_tick = 1'b1;
      bus1.i_s_tick = 1'b1;
      bus0.i_din = v;
      bus1.i_din = v;
      if (d == 0) bus0.i_tx_start = 1'b1; else bus1.i_tx_start = 1'b1;
      step();
      bus0.i_tx_start = 1'b0;
      bus1.i_tx_start = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int  n = 0;
      bit  idle = 0;
      while (!idle && n < 3000) begin
         step();
         n++;
         idle = (((d == 0) ? sbq0.size() : sbq1.size()) == 0) && !mon_active[d] && !m_busy[d];
      end
      chk($sformatf("d%0d_wait_idle_timeout", d), int'(idle), 1);
   endtask

   // Frame monitor: starts on the first low sample of the line, collects
   // until done (or reset/timeout), then checks each bit window.
   task automatic monitor(input int d);
      int last_done = -1000;
      forever begin
         @(negedge clk);
         if (!reset && !m_tx[d]) begin
            frame_t f;
            bit     have = 1;
            bit     aborted = 0;
            bit     done = 0;
            bit     busy_ok = 1;
            bit     smp[$];
            int     start_cyc = cyc;
            int     bw, sbw, nseg, lexp;
            mon_active[d] = 1;
            if ((d == 0 ? sbq0.size() : sbq1.size()) == 0) begin
               chk($sformatf("d%0d_unexpected_frame", d), 1, 0);
               have = 0;
               f.din = 8'h00; f.par = 0; f.div = 1; f.sb = 16; f.abort = 0; f.gap = 0;
            end else if (d == 0) begin
               f = sbq0.pop_front();
            end else begin
               f = sbq1.pop_front();
            end
            bw   = 16 * f.div;
            sbw  = f.sb * f.div;
            nseg = 2 + DBIT + P;
            lexp = (1 + DBIT + P) * bw + sbw;
            if (have && f.gap != 0)
               chk($sformatf("d%0d_%02h_gap_after_done", d, f.din), start_cyc - last_done, f.gap);
            while (1) begin
               smp.push_back(m_tx[d]);
               if (!m_busy[d]) busy_ok = 0;
               if (m_done[d]) begin
                  done = 1;
                  last_done = cyc;
                  break;
               end
               if (smp.size() > lexp + 64) break;
               @(negedge clk);
               if (reset) begin
                  aborted = 1;
                  break;
               end
            end
            if (have) begin
               if (f.abort) chk($sformatf("d%0d_%02h_aborted", d, f.din), int'(aborted), 1);
               else         chk($sformatf("d%0d_%02h_frame_len", d, f.din), smp.size(), lexp);
               chk($sformatf("d%0d_%02h_busy_in_frame", d, f.din), int'(busy_ok), 1);
               for (int k = 0; k < nseg; k++) begin
                  int s0 = k * bw;
                  int len = (k == nseg - 1) ? sbw : bw;
                  bit e = (k == 0) ? 1'b0 :
                          (k <= DBIT) ? f.din[k-1] :
                          (P == 1 && k == DBIT + 1) ? f.par : 1'b1;
                  if (s0 < smp.size()) begin
                     int bad_i = -1;
                     for (int i = s0; i < s0 + len && i < smp.size(); i++)
                        if (smp[i] != e && bad_i < 0) bad_i = i;
                     chk($sformatf("d%0d_%02h_seg%0d", d, f.din, k),
                         (bad_i < 0) ? int'(e) : int'(smp[bad_i]), int'(e));
                  end
               end
            end
            if (done) begin
               @(negedge clk);
               chk($sformatf("d%0d_%02h_busy_after_done", d, f.din), int'(m_busy[d]), 0);
            end
            mon_active[d] = 0;
         end
      end
   endtask

   initial monitor(0);
   initial monitor(1);

   logic [7:0] v_din [3];
   bit         v_par [3];

   initial begin
      v_din[0] = 8'h01; v_par[0] = 1'b1;
      v_din[1] = 8'h80; v_par[1] = 1'b1;
      v_din[2] = 8'h5A; v_par[2] = 1'b0;
      exp_dn[0] = 0; exp_dn[1] = 0;
      mon_active[0] = 0; mon_active[1] = 0;
      reset = 1'b1;
      bus0.i_tx_start = 1'b0; bus0.i_s_tick = 1'b0; bus0.i_din = 8'h00;
      bus1.i_tx_start = 1'b0; bus1.i_s_tick = 1'b0; bus1.i_din = 8'h00;
      repeat (3) step();
      // Reset state of both instances
      chk("d0_reset_tx",   int'(m_tx[0]),   1);
      chk("d0_reset_busy", int'(m_busy[0]), 0);
      chk("d0_reset_done", int'(m_done[0]), 0);
      chk("d1_reset_tx",   int'(m_tx[1]),   1);
      chk("d1_reset_busy", int'(m_busy[1]), 0);
      reset = 1'b0;
      repeat (2) step();

      // 0xA5 with s_tick every clk; a mid-frame start with other data is ignored
      send(0, 8'hA5, 1'b0, 1, 0);
      repeat (20) step();
      bus0.i_din = 8'hFF;
      bus0.i_tx_start = 1'b1;
      step();
      bus0.i_tx_start = 1'b0;
      wait_idle(0);

      // Parity-relevant vectors
      for (int i = 0; i < 3; i++) begin
         send(0, v_din[i], v_par[i], 1, 0);
         wait_idle(0);
      end

      // s_tick every 4th clk: every bit 64 clks wide
      send(0, 8'h3C, 1'b0, 4, 0);
      wait_idle(0);

      // tx_start held high: back-to-back frames, mid-frame din changes unsent.
      // Done clk d, acceptance in d+1, start bit on the line from d+2.
      push(0, 8'h11, 1'b0, 1, 0, 0);
      push(0, 8'h22, 1'b0, 1, 0, 2);
      div = 1; tcnt = 0;
      bus0.i_s_tick = 1'b1;
      bus0.i_din = 8'h11;
      bus0.i_tx_start = 1'b1;
      repeat (30) step();
      bus0.i_din = 8'h22;
      repeat (150) step();
      bus0.i_tx_start = 1'b0;
      bus0.i_din = 8'h5A;
      wait_idle(0);

      // Reset during data bit 3 of 0xFF aborts the frame
      send(0, 8'hFF, 1'b0, 1, 1);
      repeat (70) step();
      reset = 1'b1;
      step();
      chk("d0_abort_tx",   int'(m_tx[0]),   1);
      chk("d0_abort_busy", int'(m_busy[0]), 0);
      chk("d0_abort_done", int'(m_done[0]), 0);
      reset = 1'b0;
      step();
      send(0, 8'hFF, 1'b0, 1, 0);
      wait_idle(0);

      // SB_TICK=32 instance: stop high for 32 ticks
      send(1, 8'h00, 1'b0, 1, 0);
      wait_idle(1);

      repeat (5) step();
      chk("d0_done_count", dn_cnt[0], exp_dn[0]);
      chk("d1_done_count", dn_cnt[1], exp_dn[1]);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
